// File: rtl/noc_if_pkg.sv
// noc_if_pkg: shared flit, injector-state and synchronizer definitions for the NoC interface.
package noc_if_pkg;

    localparam int FLIT_DATA_W = 32;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic                   tail;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETUP,
        WAIT_ACK
    } inj_state_e;

endpackage

// File: rtl/ack_synchronizer.sv
// ack_synchronizer: multi-flop synchronizer with async clear that brings the router's ack phase into clk.
module ack_synchronizer
    import noc_if_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_flit_injector.sv
// sync_flit_injector: buffers valid/ready flits and replays them onto a two-phase bundled-data router port.
// Optional ack watchdog enabled by INJ_TIMEOUT_EN.
module sync_flit_injector
    import noc_if_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic                     in_tail_i,
    output logic [DATA_W:0]          data_dw_o,
    output logic                     req_dw_o,
    input  logic                     ack_dw_i,
    output logic                     packet_en_dw_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     busy_o,
    output logic                     timeout_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETUP_CYC + 1);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            push, pop, empty, full, ack_ph;
    logic [DATA_W:0] data_q, data_nx;
    logic            req_q, req_nx, pkt_open, pkt_nx;
    logic [SW-1:0]   setup_cnt, setup_nx;
    inj_state_e      state, state_nx;

    ack_synchronizer u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ack_dw_i),
        .q       (ack_ph)
    );

    assign fifo_level_o   = wr_ptr - rd_ptr;
    assign empty          = wr_ptr == rd_ptr;
    assign full           = fifo_level_o == (AW+1)'(DEPTH);
    assign pop            = state == WAIT_ACK && ack_ph == req_q;
    // A slot freed by this cycle's pop may be refilled in the same cycle.
    assign in_ready_o     = !full || pop;
    assign push           = in_valid_i && in_ready_o;
    assign data_dw_o      = data_q;
    assign req_dw_o       = req_q;
    assign packet_en_dw_o = pkt_open;
    assign busy_o         = state != IDLE || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_tail_i, in_data_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + (AW+1)'(1) : wr_ptr;
            rd_ptr <= pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            setup_cnt <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            pkt_open  <= 1'b0;
        end else begin
            state     <= state_nx;
            setup_cnt <= setup_nx;
            data_q    <= data_nx;
            req_q     <= req_nx;
            pkt_open  <= pkt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        setup_nx = setup_cnt;
        data_nx  = data_q;
        req_nx   = req_q;
        pkt_nx   = pkt_open;
        case (state)
            IDLE: state_nx = empty ? IDLE : LOAD;
            LOAD: begin
                data_nx  = mem[rd_ptr[AW-1:0]];
                pkt_nx   = 1'b1;
                setup_nx = SW'(SETUP_CYC - 1);
                state_nx = SETUP;
            end
            SETUP: begin
                setup_nx = setup_cnt == '0 ? setup_cnt : setup_cnt - SW'(1);
                req_nx   = setup_cnt == '0 ? ~req_q : req_q;
                state_nx = setup_cnt == '0 ? WAIT_ACK : SETUP;
            end
            WAIT_ACK: begin
                pkt_nx   = pop ? pkt_open & ~data_q[DATA_W] : pkt_open;
                // Leave for IDLE only when the popped flit was the last one and nothing arrives alongside.
                state_nx = !pop ? WAIT_ACK : (fifo_level_o == (AW+1)'(1) && !push) ? IDLE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef INJ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_ACK && !pop) ? (to_cnt == TW'(TIMEOUT) ? to_cnt : to_cnt + TW'(1)) : '0;
            // Outside WAIT_ACK the phases must agree; any difference is an unsolicited ack toggle.
            if ((state == WAIT_ACK && to_cnt == TW'(TIMEOUT)) || (state != WAIT_ACK && ack_ph != req_q))
                err_q <= 1'b1;
        end
    end

    assign timeout_err_o = err_q;
`else
    assign timeout_err_o = TIMEOUT < 0;
`endif

endmodule

// File: tb/tb_sync_flit_injector.sv
// tb_sync_flit_injector: directed and randomized-latency checks of the flit injector against a
// behavioural two-phase router responder and an ordering scoreboard.
module tb_sync_flit_injector;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_tail = 1'b0;
    logic [32:0] data_dw;
    logic        req_dw;
    logic        ack = 1'b0;
    logic        packet_en;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        timeout_err;

    int ntests = 0;
    int nfail = 0;
    int toggles = 0;
    int pe_falls = 0;
    int unstable = 0;
    int ack_dly = 0;
    int rdly = 0;
    int wc = 0;
    bit ack_hold = 1'b0;
    bit rnd = 1'b0;
    logic [32:0] sb[$];
    logic [32:0] held = '0;
    logic prev_req = 1'b0;
    logic prev_pe = 1'b0;

    always #5 clk = ~clk;

    sync_flit_injector #(.DATA_W(32), .DEPTH(4), .SETUP_CYC(2), .TIMEOUT(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_tail_i      (in_tail),
        .data_dw_o      (data_dw),
        .req_dw_o       (req_dw),
        .ack_dw_i       (ack),
        .packet_en_dw_o (packet_en),
        .fifo_level_o   (fifo_level),
        .busy_o         (busy),
        .timeout_err_o  (timeout_err)
    );

    // Router side: answers each req toggle with an ack toggle after a programmable number of cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack <= 1'b0;
            wc  <= 0;
        end else if (!ack_hold && req_dw != ack) begin
            if (wc >= (rnd ? rdly : ack_dly)) begin
                ack  <= req_dw;
                wc   <= 0;
                rdly <= $urandom_range(0, 20);
            end else begin
                wc <= wc + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and bundling monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_req = 1'b0;
                prev_pe  = 1'b0;
                sb.delete();
            end else begin
                if (req_dw != prev_req) begin
                    toggles++;
                    held = data_dw;
                    if (sb.size() == 0) chk("sb_underflow", 1, 0);
                    else chk("sb_order", data_dw, sb.pop_front());
                end else if (req_dw != ack && data_dw != held) begin
                    unstable++;
                end
                if (prev_pe && !packet_en) pe_falls++;
                prev_req = req_dw;
                prev_pe  = packet_en;
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic t);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_tail  = t;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_ready_wait", 0, 1);
            in_valid = 1'b0;
        end else begin
            sb.push_back({t, d});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || req_dw != ack) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        int t0;
        int f0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_req", req_dw, 0);
        chk("rst_data", data_dw, 0);
        chk("rst_pkt_en", packet_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        reset_n = 1'b1;

        // Single tail flit, responder acks three cycles after req.
        ack_dly = 2;
        push(32'hA5, 1'b1);
        @(negedge clk);
        chk("t1_level", fifo_level, 1);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_data_preload", data_dw, 0);
        @(negedge clk);
        chk("t1_data_load", data_dw, 33'h1_0000_00A5);
        chk("t1_pkt_en_rise", packet_en, 1);
        chk("t1_req_setup0", req_dw, 0);
        @(negedge clk);
        chk("t1_req_setup1", req_dw, 0);
        @(negedge clk);
        chk("t1_req_toggle", req_dw, 1);
        repeat (5) @(negedge clk);
        chk("t1_pkt_en_held", packet_en, 1);
        @(negedge clk);
        chk("t1_pkt_en_fall", packet_en, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_level_done", fifo_level, 0);

        // Four-flit packet with a zero-delay responder.
        do_reset();
        ack_dly = 0;
        t0 = toggles;
        f0 = pe_falls;
        for (int i = 0; i < 4; i++) push(32'h100 + i, i == 3);
        wait_idle(300);
        chk("t2_toggles", toggles - t0, 4);
        chk("t2_req_final", req_dw, 0);
        chk("t2_pkt_en_falls", pe_falls - f0, 1);
        chk("t2_pkt_en_end", packet_en, 0);

        // Fill the FIFO while ack is withheld, then push and pop in one cycle.
        do_reset();
        ack_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h200 + i, i == 3);
        @(negedge clk);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_full_level", fifo_level, 4);
        ack_hold = 1'b0;
        push(32'h204, 1'b1);
        chk("t3_pushpop_level", fifo_level, 4);
        wait_idle(300);
        chk("t3_sb_empty", sb.size(), 0);

        // Reset in the middle of a handshake with two flits queued.
        do_reset();
        ack_hold = 1'b1;
        push(32'h300, 1'b0);
        push(32'h301, 1'b1);
        for (int n = 0; n < 50 && !req_dw; n++) @(negedge clk);
        chk("t4_in_wait_ack", req_dw, 1);
        reset_n = 1'b0;
        #1;
        chk("t4_async_req", req_dw, 0);
        chk("t4_async_pkt_en", packet_en, 0);
        chk("t4_async_level", fifo_level, 0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        ack_hold = 1'b0;
        @(negedge clk);
        chk("t4_ready_after", in_ready, 1);
        chk("t4_busy_after", busy, 0);

        // Random ack latency with random packet boundaries.
        rnd = 1'b1;
        for (int i = 0; i < 1000; i++) push($urandom, i == 999 || $urandom_range(0, 3) == 0);
        wait_idle(2000);
        chk("t5_data_stable", unstable, 0);
        chk("t5_sb_empty", sb.size(), 0);
        chk("t5_pkt_en_end", packet_en, 0);
        rnd = 1'b0;

`ifdef INJ_TIMEOUT_EN
        // Withheld ack trips the watchdog nine cycles after the req toggle.
        do_reset();
        ack_hold = 1'b1;
        push(32'h600, 1'b1);
        for (int n = 0; n < 50 && !req_dw; n++) @(negedge clk);
        chk("t6_req_toggle", req_dw, 1);
        repeat (8) @(negedge clk);
        chk("t6_err_before", timeout_err, 0);
        @(negedge clk);
        chk("t6_err_set", timeout_err, 1);
        ack_hold = 1'b0;
        wait_idle(200);
        chk("t6_err_sticky", timeout_err, 1);
`else
        chk("t6_err_tied", timeout_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
